// File: rtl/rvfi_csr_shadow_check.sv
// rtl/rvfi_csr_shadow_check.sv - per-bit CSR shadow and read consistency checker on RVFI retirements
module rvfi_csr_shadow_check #(
  parameter int NRET     = 2,
  parameter int CSR_W    = 64,
  parameter int CNT_MODE = 0,
  parameter int ERRCNT_W = 8,
  localparam int CHAN_W  = $clog2(NRET) + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  check_en,
  input  logic [NRET-1:0]       rvfi_valid,
  input  logic [NRET-1:0]       rvfi_trap,
  input  logic [NRET*CSR_W-1:0] rvfi_csr_rmask,
  input  logic [NRET*CSR_W-1:0] rvfi_csr_rdata,
  input  logic [NRET*CSR_W-1:0] rvfi_csr_wmask,
  input  logic [NRET*CSR_W-1:0] rvfi_csr_wdata,
  output logic [CSR_W-1:0]      shadow_value,
  output logic [CSR_W-1:0]      shadow_known,
  output logic                  err,
  output logic [CHAN_W-1:0]     err_chan,
  output logic [1:0]            err_kind,
  output logic [ERRCNT_W-1:0]   err_count
);

  logic [CSR_W-1:0]    nxt_shadow;
  logic [CSR_W-1:0]    nxt_known;
  logic [CSR_W-1:0]    rm;
  logic [CSR_W-1:0]    rd;
  logic [CSR_W-1:0]    wm;
  logic [CSR_W-1:0]    wd;
  logic                mm;
  logic                tw;
  logic                any_err;
  logic [CHAN_W-1:0]   first_chan;
  logic [1:0]          first_kind;
  int                  nerr;
  logic [ERRCNT_W:0]   cnt_sum;
  logic [ERRCNT_W-1:0] nxt_count;

  // Walk channels oldest-first so each one sees the shadow left by the channels before it
  always_comb begin
    nxt_shadow = shadow_value;
    nxt_known  = shadow_known;
    rm         = '0;
    rd         = '0;
    wm         = '0;
    wd         = '0;
    mm         = 1'b0;
    tw         = 1'b0;
    any_err    = 1'b0;
    first_chan = '0;
    first_kind = '0;
    nerr       = 0;
    for (int i = 0; i < NRET; i++) begin
      if (rvfi_valid[i]) begin
        rm = rvfi_csr_rmask[i*CSR_W +: CSR_W];
        rd = rvfi_csr_rdata[i*CSR_W +: CSR_W];
        wm = rvfi_csr_wmask[i*CSR_W +: CSR_W];
        wd = rvfi_csr_wdata[i*CSR_W +: CSR_W];
        mm = check_en & (|(rm & nxt_known & (rd ^ nxt_shadow)));
        tw = check_en & rvfi_trap[i] & (|wm);
        if (mm | tw) begin
          nerr = nerr + 1;
          if (!any_err) begin
            any_err    = 1'b1;
            first_chan = CHAN_W'(i);
            first_kind = {tw, mm};
          end
        end
        if (!rvfi_trap[i]) begin
          if (wm != '0) begin
            nxt_shadow = (nxt_shadow & ~wm) | (wd & wm);
            nxt_known  = nxt_known | wm;
          end else if (CNT_MODE != 0) begin
            // An increment of a partially known value has an untrackable carry
            if (&nxt_known) nxt_shadow = nxt_shadow + 1'b1;
            else            nxt_known  = '0;
          end
        end
      end
    end
    cnt_sum   = {1'b0, err_count} + (ERRCNT_W+1)'(nerr);
    nxt_count = (cnt_sum > {1'b0, {ERRCNT_W{1'b1}}}) ? {ERRCNT_W{1'b1}} : cnt_sum[ERRCNT_W-1:0];
  end

  // Register shadow state, sticky first-error record and saturating error count
  always_ff @(posedge clock) begin
    if (!reset) begin
      shadow_value <= '0;
      shadow_known <= '0;
      err          <= 1'b0;
      err_chan     <= '0;
      err_kind     <= '0;
      err_count    <= '0;
    end else begin
      shadow_value <= nxt_shadow;
      shadow_known <= nxt_known;
      err_count    <= nxt_count;
      if (!err && any_err) begin
        err      <= 1'b1;
        err_chan <= first_chan;
        err_kind <= first_kind;
      end
    end
  end

endmodule

// File: tb/tb_rvfi_csr_shadow_check.sv
// tb/tb_rvfi_csr_shadow_check.sv - directed bench for rvfi_csr_shadow_check in plain and counter modes
module tb_rvfi_csr_shadow_check;

  logic         clock = 1'b0;
  logic         reset;
  logic         check_en;
  logic [1:0]   valid;
  logic [1:0]   trap;
  logic [127:0] rmask, rdata, wmask, wdata;

  logic [63:0]  sv [2];
  logic [63:0]  kn [2];
  logic         er [2];
  logic [1:0]   ec [2];
  logic [1:0]   ek [2];
  logic [7:0]   cnt [2];

  int vectors = 0;
  int miscompares = 0;
  bit cmp_on = 0;

  // model state: index 0 plain register, index 1 counter mode
  logic [63:0] m_sh [2];
  logic [63:0] m_kn [2];
  bit          m_err [2];
  int          m_chan [2];
  int          m_kind [2];
  int          m_cnt [2];

  always #5 clock = ~clock;

  rvfi_csr_shadow_check #(.NRET(2), .CSR_W(64), .CNT_MODE(0), .ERRCNT_W(8)) d0 (
    .clock(clock), .reset(reset), .check_en(check_en), .rvfi_valid(valid), .rvfi_trap(trap),
    .rvfi_csr_rmask(rmask), .rvfi_csr_rdata(rdata), .rvfi_csr_wmask(wmask), .rvfi_csr_wdata(wdata),
    .shadow_value(sv[0]), .shadow_known(kn[0]), .err(er[0]), .err_chan(ec[0]), .err_kind(ek[0]),
    .err_count(cnt[0]));

  rvfi_csr_shadow_check #(.NRET(2), .CSR_W(64), .CNT_MODE(1), .ERRCNT_W(8)) d1 (
    .clock(clock), .reset(reset), .check_en(check_en), .rvfi_valid(valid), .rvfi_trap(trap),
    .rvfi_csr_rmask(rmask), .rvfi_csr_rdata(rdata), .rvfi_csr_wmask(wmask), .rvfi_csr_wdata(wdata),
    .shadow_value(sv[1]), .shadow_known(kn[1]), .err(er[1]), .err_chan(ec[1]), .err_kind(ek[1]),
    .err_count(cnt[1]));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Bit-level reference: each bit of the CSR is tracked as a (known, value) pair
  logic [63:0] s, k;
  int ne, fchan, fkind;
  bit mm, tw, anyw, seen;
  always @(posedge clock) begin
    for (int m = 0; m < 2; m++) begin
      if (!reset) begin
        m_sh[m] = 0; m_kn[m] = 0; m_err[m] = 0; m_chan[m] = 0; m_kind[m] = 0; m_cnt[m] = 0;
      end else begin
        s = m_sh[m]; k = m_kn[m]; ne = 0; seen = 0; fchan = 0; fkind = 0;
        for (int c = 0; c < 2; c++) begin
          if (valid[c]) begin
            mm = 0; anyw = 0;
            for (int b = 0; b < 64; b++) begin
              if (rmask[c*64+b] && k[b] && (rdata[c*64+b] != s[b])) mm = check_en;
              if (wmask[c*64+b]) anyw = 1;
            end
            tw = check_en && trap[c] && anyw;
            if (mm || tw) begin
              ne++;
              if (!seen) begin seen = 1; fchan = c; fkind = (tw ? 2 : 0) + (mm ? 1 : 0); end
            end
            if (!trap[c]) begin
              if (anyw) begin
                for (int b = 0; b < 64; b++)
                  if (wmask[c*64+b]) begin s[b] = wdata[c*64+b]; k[b] = 1'b1; end
              end else if (m == 1) begin
                if (k == {64{1'b1}}) s = s + 64'd1;
                else k = 64'd0;
              end
            end
          end
        end
        m_sh[m] = s; m_kn[m] = k;
        if (seen && !m_err[m]) begin m_err[m] = 1; m_chan[m] = fchan; m_kind[m] = fkind; end
        m_cnt[m] = (m_cnt[m] + ne > 255) ? 255 : m_cnt[m] + ne;
      end
    end
  end

  // Every cycle, both instances must agree with the model
  always @(negedge clock) begin
    if (cmp_on) begin
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("model.shadow[%0d]", m), sv[m], m_sh[m]);
        chk($sformatf("model.known[%0d]", m), kn[m], m_kn[m]);
        chk($sformatf("model.err[%0d]", m), {63'd0, er[m]}, {63'd0, m_err[m]});
        chk($sformatf("model.chan[%0d]", m), {62'd0, ec[m]}, 64'(m_chan[m]));
        chk($sformatf("model.kind[%0d]", m), {62'd0, ek[m]}, 64'(m_kind[m]));
        chk($sformatf("model.count[%0d]", m), {56'd0, cnt[m]}, 64'(m_cnt[m]));
      end
    end
  end

  task automatic idle();
    valid = 0; trap = 0; rmask = 0; rdata = 0; wmask = 0; wdata = 0;
  endtask

  task automatic set_ch(input int c, input logic t, input logic [63:0] rm, input logic [63:0] rd,
                        input logic [63:0] wm, input logic [63:0] wd);
    valid[c] = 1'b1; trap[c] = t;
    rmask[c*64 +: 64] = rm; rdata[c*64 +: 64] = rd;
    wmask[c*64 +: 64] = wm; wdata[c*64 +: 64] = wd;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    idle();
  endtask

  initial begin
    reset = 0; check_en = 1; idle();
    step(); step();
    cmp_on = 1;
    chk("reset.shadow", sv[0], 64'd0);
    chk("reset.known", kn[0], 64'd0);
    chk("reset.count", {56'd0, cnt[0]}, 64'd0);
    reset = 1;

    // invalid channel carrying garbage changes nothing
    trap = 2'b11; wmask = '1; wdata = '1; rmask = '1; rdata = 128'h1234;
    step();
    chk("invalid.known", kn[0], 64'd0);
    chk("invalid.err", {63'd0, er[0]}, 64'd0);

    // write A5 then read it back
    set_ch(0, 0, 0, 0, 64'hFF, 64'hA5); step();
    set_ch(0, 0, 64'hFF, 64'hA5, 0, 0); step();
    chk("t1.err", {63'd0, er[0]}, 64'd0);
    chk("t1.known", kn[0], 64'hFF);
    chk("t1.shadow", sv[0], 64'hA5);

    // mismatching read
    set_ch(0, 0, 64'hFF, 64'hA4, 0, 0); step();
    chk("t2.err", {63'd0, er[0]}, 64'd1);
    chk("t2.kind", {62'd0, ek[0]}, 64'd1);
    chk("t2.chan", {62'd0, ec[0]}, 64'd0);
    chk("t2.count", {56'd0, cnt[0]}, 64'd1);

    // same-cycle write then read forwards
    set_ch(0, 0, 0, 0, 64'hFF, 64'h3C);
    set_ch(1, 0, 64'hFF, 64'h3C, 0, 0); step();
    chk("t3.count", {56'd0, cnt[0]}, 64'd1);
    chk("t3.shadow", sv[0], 64'h3C);

    // counter wrap from all ones with two retirements
    set_ch(0, 0, 0, 0, '1, '1); step();
    set_ch(0, 0, 0, 0, 0, 0);
    set_ch(1, 0, 0, 0, 0, 0); step();
    chk("t4.cnt_shadow", sv[1], 64'd1);
    chk("t4.cnt_known", kn[1], '1);
    chk("t4.plain_shadow", sv[0], '1);

    // ch0 mismatch plus ch1 trapping write
    set_ch(0, 0, 64'hFF, 64'h00, 0, 0);
    set_ch(1, 1, 0, 0, 64'h1, 64'h0); step();
    chk("t5.plain_count", {56'd0, cnt[0]}, 64'd3);
    chk("t5.plain_kind", {62'd0, ek[0]}, 64'd1);
    chk("t5.plain_shadow", sv[0], '1);
    chk("t5.cnt_count", {56'd0, cnt[1]}, 64'd2);
    chk("t5.cnt_chan", {62'd0, ec[1]}, 64'd0);
    chk("t5.cnt_kind", {62'd0, ek[1]}, 64'd1);
    chk("t5.cnt_shadow", sv[1], 64'd2);

    // check_en low: shadow follows writes, trap and mismatch ignored
    check_en = 0;
    set_ch(0, 0, 0, 0, 64'hFF, 64'h55);
    set_ch(1, 1, 64'hFF, 64'h00, 64'hFF, 64'h00); step();
    check_en = 1;
    chk("noen.count", {56'd0, cnt[0]}, 64'd3);
    chk("noen.shadow", sv[0], 64'hFFFF_FFFF_FFFF_FF55);

    // reset with an in-flight write
    set_ch(0, 0, 0, 0, 64'hFF, 64'h77); step();
    chk("t6.pre_known", kn[0], '1);
    reset = 0;
    set_ch(0, 0, 0, 0, 64'hFF, 64'h99); step();
    reset = 1;
    chk("t6.shadow", sv[0], 64'd0);
    chk("t6.known", kn[0], 64'd0);
    chk("t6.err", {63'd0, er[0]}, 64'd0);
    chk("t6.kind", {62'd0, ek[0]}, 64'd0);
    chk("t6.count", {56'd0, cnt[0]}, 64'd0);

    // first error on ch1 with both kinds
    set_ch(0, 0, 0, 0, 64'hFF, 64'h0F);
    set_ch(1, 1, 64'hFF, 64'hF0, 64'h1, 64'h0); step();
    chk("both.chan", {62'd0, ec[0]}, 64'd1);
    chk("both.kind", {62'd0, ek[0]}, 64'd3);
    chk("both.count", {56'd0, cnt[0]}, 64'd1);
    chk("both.cnt_kind", {62'd0, ek[1]}, 64'd3);

    // saturation of the error counter
    for (int n = 0; n < 130; n++) begin
      set_ch(0, 0, 64'hFF, 64'hF0, 0, 0);
      set_ch(1, 0, 64'hFF, 64'hF0, 0, 0);
      step();
    end
    chk("sat.count", {56'd0, cnt[0]}, 64'd255);
    chk("sat.chan", {62'd0, ec[0]}, 64'd1);

    step();
    @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
